stat_arb: RTL and testbench
===========================

# stat_arb

Two-requester write arbiter and read sequencer for the 4 x 8-bit AES status register file (mem4). Host bus and AES core both raise write requests. The block grants them round-robin through a single registered write port, and it serves host reads with a fixed 2-cycle latency. It sits between the bus interface, the AES core, and the mem4 instance.

## Interface
Parameters:
- DW, 8, data width; must match mem4.
- AW, 2, address width; register file depth is 2^AW = 4.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- h_wreq  in  1  host write request; held until ack.
- h_waddr  in  AW  host write address; stable while h_wreq=1.
- h_wdata  in  DW  host write data; stable while h_wreq=1.
- h_wack  out  1  host write accepted; 1-cycle pulse.
- c_wreq  in  1  core write request; held until ack.
- c_waddr  in  AW  core write address.
- c_wdata  in  DW  core write data.
- c_wack  out  1  core write accepted; 1-cycle pulse.
- h_rreq  in  1  host read request; single-cycle strobe.
- h_raddr  in  AW  host read address.
- h_rdata  out  DW  read data; valid when h_rvalid=1, held otherwise.
- h_rvalid  out  1  read data valid; 1-cycle pulse.
- mem_en  out  1  to mem4 en.
- mem_we  out  1  to mem4 we.
- mem_aw  out  AW  to mem4 aw.
- mem_din  out  DW  to mem4 din.
- mem_ar  out  AW  to mem4 ar.
- mem_dout  in  DW  from mem4 dout; combinational read.

## Operation
- All outputs are registered.
- Reset values:
  - h_wack=0, c_wack=0, h_rvalid=0.
  - mem_en=0, mem_we=0.
  - mem_aw=0, mem_din=0, mem_ar=0.
  - h_rdata=0.
  - Priority pointer prio=HOST.
- Effective requests:
  - h_eff = h_wreq & ~h_wack.
  - c_eff = c_wreq & ~c_wack.
  - A requester is masked in the cycle its ack is high. This prevents a double grant while it drops req.
- Write FSM has two states:
  - IDLE: mem_en=mem_we=0.
  - ISSUE: mem_en=mem_we=1 for exactly one cycle.
- IDLE to ISSUE when h_eff|c_eff. Grant selection:
  - Only one effective request: that requester wins.
  - Both effective: the requester equal to prio wins.
- On entering ISSUE:
  - mem_aw/mem_din load the winner's address and data.
  - The winner's ack is set.
  - prio flips to the loser; with a single requester, prio is set to the other requester.
- ISSUE to ISSUE if another effective request exists (back-to-back writes); otherwise ISSUE to IDLE.
- The masked requester cannot win in the cycle its ack is high. So one requester alone issues at most every other cycle. Two requesters alternate with a write every cycle.
- Same address from both requesters: both writes occur in grant order; the later one persists.
- Read path:
  - h_rreq at edge e loads mem_ar=h_raddr and sets rd_pend.
  - At edge e+1 with rd_pend=1: h_rdata loads mem_dout (or the bypass value), and h_rvalid=1 for one cycle.
- Reads and writes are independent and proceed concurrently. h_rreq may be asserted every cycle; reads are fully pipelined.
- Reset mid-operation: all state clears immediately. Pending acks, reads and in-flight writes are dropped; requesters re-issue.

## Timing
- Write: request sampled at edge N.
  - mem_we and ack are high in cycle N+1.
  - mem4 stores at edge N+2.
  - Data is readable on mem_dout from cycle N+2.
- The requester samples ack at the end of cycle N+1. It may present a new request from cycle N+2.
- Read latency: h_rreq in cycle N gives h_rvalid and h_rdata in cycle N+2.
- Read/write hazard: mem_we=1 with mem_aw==mem_ar in the cycle h_rdata is captured. Behaviour depends on STAT_ARB_RDBYP_EN.

## Configuration
- Macro STAT_ARB_RDBYP_EN.
- Defined: on the hazard above, h_rdata captures mem_din, i.e. the value being written (read-after-write forwarding).
- Undefined: h_rdata captures mem_dout, i.e. the old value. Software must then allow one idle cycle between a write and a read of the same address.

## Structure
- Package stat_arb_pkg:
  - Requester ID constants REQ_HOST=1'b0 and REQ_CORE=1'b1.
  - FSM state encodings ST_IDLE and ST_ISSUE.
  - Default DW and AW.
- Sub-module rr_arb2: combinational 2-way round-robin pick.
  - Inputs: h_eff, c_eff, prio.
  - Outputs: grant valid, winner ID.
- The stat_arb top holds the FSM, the prio register, the output registers and the read pipeline.

## Test plan
- Reset, then h_wreq addr=2 data=0x5A → h_wack and mem_we high in cycle 2 with mem_aw=2, mem_din=0x5A. A read of addr 2 afterwards returns 0x5A with latency 2.
- h_wreq and c_wreq both asserted continuously after reset, addresses 0/1 → grants go HOST, CORE, HOST, CORE on consecutive cycles with no idle cycle.
- Single host requester holding req through ack then immediately re-requesting → no double write; mem_we duty is 1 in 2.
- Both requesters write addr 3 simultaneously: host 0x11, core 0x22, prio=HOST → final read of addr 3 returns 0x22.
- Write 0x77 to addr 1, read addr 1 in the same cycle mem_we is high → 0x77 with STAT_ARB_RDBYP_EN, previous value 0x00 without.
- rstn asserted in the ISSUE cycle → mem_we, acks and h_rvalid are 0 immediately; register file contents remain 0.

Source files
------------

// File: rtl/stat_arb_pkg.sv
// stat_arb_pkg: shared constants for the mem4 status-register arbiter.
// Requester IDs, write FSM state encoding and default bus widths.
package stat_arb_pkg;

   // Default data / address widths (must match the mem4 instance)
   localparam int DW_DEF = 8;
   localparam int AW_DEF = 2;

   // Requester identifiers; also the encoding of the priority pointer
   localparam logic REQ_HOST = 1'b0;
   localparam logic REQ_CORE = 1'b1;

   // Write FSM states
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } wr_state_t;

   // Return the requester that is not 'id' (used to hand priority to the loser)
   function automatic logic other_req(input logic id);
      return (id == REQ_HOST) ? REQ_CORE : REQ_HOST;
   endfunction

endpackage

// File: rtl/stat_arb_rr.sv
// rr_arb2: combinational two-way round-robin pick between host and core.
// A lone effective request always wins; on contention the requester equal
// to the priority pointer wins.
module rr_arb2
   import stat_arb_pkg::*;
(
   input  logic i_h_eff,
   input  logic i_c_eff,
   input  logic i_prio,
   output logic o_gnt_vld,
   output logic o_winner
);

   // Pick the winner from the effective requests and the priority pointer
   always_comb begin
      o_gnt_vld = i_h_eff | i_c_eff;
      o_winner  = REQ_HOST;
      if (i_h_eff && i_c_eff) begin
         o_winner = i_prio;
      end else if (i_c_eff) begin
         o_winner = REQ_CORE;
      end
   end

endmodule

// File: rtl/stat_arb.sv
// stat_arb: round-robin write arbiter and 2-cycle read sequencer for the
// 4 x 8-bit AES status register file (mem4).
// Optional feature macro: STAT_ARB_RDBYP_EN -- when defined, a read that is
// captured in the same cycle as a write to the same address returns the
// value being written instead of the old memory contents.
module stat_arb
   import stat_arb_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
)(
   input  logic          clk,
   input  logic          rstn,
   // host write port
   input  logic          h_wreq,
   input  logic [AW-1:0] h_waddr,
   input  logic [DW-1:0] h_wdata,
   output logic          h_wack,
   // core write port
   input  logic          c_wreq,
   input  logic [AW-1:0] c_waddr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_wack,
   // host read port
   input  logic          h_rreq,
   input  logic [AW-1:0] h_raddr,
   output logic [DW-1:0] h_rdata,
   output logic          h_rvalid,
   // mem4 interface
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_aw,
   output logic [DW-1:0] mem_din,
   output logic [AW-1:0] mem_ar,
   input  logic [DW-1:0] mem_dout
);

   // write-side state
   wr_state_t     r_state;
   wr_state_t     w_state_nxt;
   logic          r_prio;
   logic          r_h_wack;
   logic          r_c_wack;
   logic          r_mem_en;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_aw;
   logic [DW-1:0] r_mem_din;

   // read-side state
   logic [AW-1:0] r_mem_ar;
   logic          r_rd_pend;
   logic [DW-1:0] r_h_rdata;
   logic          r_h_rvalid;

   // combinational arbitration
   logic          w_h_eff;
   logic          w_c_eff;
   logic          w_gnt_vld;
   logic          w_winner;
   logic          w_issue_nxt;
   logic [DW-1:0] w_rd_val;

   // A requester whose ack is high this cycle is still holding req; mask it
   // so the same transfer is not granted twice.
   assign w_h_eff = h_wreq & ~r_h_wack;
   assign w_c_eff = c_wreq & ~r_c_wack;

   rr_arb2 u_rr_arb2 (
      .i_h_eff   (w_h_eff),
      .i_c_eff   (w_c_eff),
      .i_prio    (r_prio),
      .o_gnt_vld (w_gnt_vld),
      .o_winner  (w_winner)
   );

   // Write FSM state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Write FSM next-state: issue whenever any effective request is pending
   always_comb begin
      w_state_nxt = ST_IDLE;
      w_issue_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_gnt_vld) begin
               w_state_nxt = ST_ISSUE;
               w_issue_nxt = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (w_gnt_vld) begin
               w_state_nxt = ST_ISSUE;
               w_issue_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_issue_nxt = 1'b0;
         end
      endcase
   end

   // Write port registers: strobe, acks, priority hand-off and address/data
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_mem_en  <= 1'b0;
         r_mem_we  <= 1'b0;
         r_h_wack  <= 1'b0;
         r_c_wack  <= 1'b0;
         r_prio    <= REQ_HOST;
         r_mem_aw  <= '0;
         r_mem_din <= '0;
      end else begin
         r_mem_en <= w_issue_nxt;
         r_mem_we <= w_issue_nxt;
         r_h_wack <= w_issue_nxt && (w_winner == REQ_HOST);
         r_c_wack <= w_issue_nxt && (w_winner == REQ_CORE);
         if (w_issue_nxt) begin
            r_prio <= other_req(w_winner);
            if (w_winner == REQ_HOST) begin
               r_mem_aw  <= h_waddr;
               r_mem_din <= h_wdata;
            end else begin
               r_mem_aw  <= c_waddr;
               r_mem_din <= c_wdata;
            end
         end
      end
   end

`ifdef STAT_ARB_RDBYP_EN
   // Forward the in-flight write when it targets the address being read
   assign w_rd_val = (r_mem_we && (r_mem_aw == r_mem_ar)) ? r_mem_din : mem_dout;
`else
   // Old contents are returned on a same-cycle write; software spaces accesses
   assign w_rd_val = mem_dout;
`endif

   // Read pipeline: stage 1 presents the address, stage 2 captures data
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_mem_ar   <= '0;
         r_rd_pend  <= 1'b0;
         r_h_rvalid <= 1'b0;
         r_h_rdata  <= '0;
      end else begin
         r_rd_pend  <= h_rreq;
         r_h_rvalid <= r_rd_pend;
         if (h_rreq) begin
            r_mem_ar <= h_raddr;
         end
         if (r_rd_pend) begin
            r_h_rdata <= w_rd_val;
         end
      end
   end

   assign h_wack   = r_h_wack;
   assign c_wack   = r_c_wack;
   assign mem_en   = r_mem_en;
   assign mem_we   = r_mem_we;
   assign mem_aw   = r_mem_aw;
   assign mem_din  = r_mem_din;
   assign mem_ar   = r_mem_ar;
   assign h_rdata  = r_h_rdata;
   assign h_rvalid = r_h_rvalid;

endmodule

// File: tb/tb_stat_arb.sv
// tb_stat_arb: directed bench for stat_arb with a behavioural mem4 model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_stat_arb;

   localparam int DW = 8;
   localparam int AW = 2;

   logic          clk;
   logic          rstn;
   logic          h_wreq;
   logic [AW-1:0] h_waddr;
   logic [DW-1:0] h_wdata;
   logic          h_wack;
   logic          c_wreq;
   logic [AW-1:0] c_waddr;
   logic [DW-1:0] c_wdata;
   logic          c_wack;
   logic          h_rreq;
   logic [AW-1:0] h_raddr;
   logic [DW-1:0] h_rdata;
   logic          h_rvalid;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_aw;
   logic [DW-1:0] mem_din;
   logic [AW-1:0] mem_ar;
   logic [DW-1:0] mem_dout;

   logic [DW-1:0] mem [4];

   int n_total = 0;
   int n_pass  = 0;

   stat_arb #(.DW(DW), .AW(AW)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .h_wreq   (h_wreq),
      .h_waddr  (h_waddr),
      .h_wdata  (h_wdata),
      .h_wack   (h_wack),
      .c_wreq   (c_wreq),
      .c_waddr  (c_waddr),
      .c_wdata  (c_wdata),
      .c_wack   (c_wack),
      .h_rreq   (h_rreq),
      .h_raddr  (h_raddr),
      .h_rdata  (h_rdata),
      .h_rvalid (h_rvalid),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_aw   (mem_aw),
      .mem_din  (mem_din),
      .mem_ar   (mem_ar),
      .mem_dout (mem_dout)
   );

   // mem4 model: synchronous write, combinational read
   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_aw] <= mem_din;
   end
   assign mem_dout = mem[mem_ar];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // issue a single-cycle read strobe and check data two cycles later
   task automatic do_read(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
      h_rreq  = 1'b1;
      h_raddr = addr;
      cyc();
      h_rreq  = 1'b0;
      chk({tag, "_rvalid_early"}, h_rvalid, 0);
      cyc();
      chk({tag, "_rvalid"}, h_rvalid, 1);
      chk({tag, "_rdata"}, h_rdata, exp);
      cyc();
      chk({tag, "_rvalid_pulse"}, h_rvalid, 0);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      cyc();
      cyc();
      rstn = 1'b1;
      cyc();
   endtask

   logic [DW-1:0] hz_exp;

   initial begin
      for (int i = 0; i < 4; i++) mem[i] = '0;
      rstn = 1'b0;
      h_wreq = 0; h_waddr = 0; h_wdata = 0;
      c_wreq = 0; c_waddr = 0; c_wdata = 0;
      h_rreq = 0; h_raddr = 0;
      cyc();
      cyc();

      // ---- reset state
      chk("rst_h_wack", h_wack, 0);
      chk("rst_c_wack", c_wack, 0);
      chk("rst_rvalid", h_rvalid, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_aw", mem_aw, 0);
      chk("rst_mem_din", mem_din, 0);
      chk("rst_mem_ar", mem_ar, 0);
      chk("rst_rdata", h_rdata, 0);
      rstn = 1'b1;
      cyc();

      // ---- reset asserted during the ISSUE cycle (with a read completing)
      h_rreq = 1'b1; h_raddr = 2'd3;
      cyc();
      h_rreq = 1'b0;
      h_wreq = 1'b1; h_waddr = 2'd0; h_wdata = 8'hEE;
      cyc();
      chk("rsti_pre_we", mem_we, 1);
      chk("rsti_pre_ack", h_wack, 1);
      chk("rsti_pre_rvalid", h_rvalid, 1);
      rstn = 1'b0;
      #1;
      chk("rsti_we", mem_we, 0);
      chk("rsti_en", mem_en, 0);
      chk("rsti_ack", h_wack, 0);
      chk("rsti_rvalid", h_rvalid, 0);
      cyc();
      h_wreq = 1'b0;
      cyc();
      rstn = 1'b1;
      cyc();
      do_read("rsti_rd0", 2'd0, 8'h00);

      // ---- basic host write addr 2 = 0x5A
      h_wreq = 1'b1; h_waddr = 2'd2; h_wdata = 8'h5A;
      cyc();
      chk("wr_ack", h_wack, 1);
      chk("wr_we", mem_we, 1);
      chk("wr_en", mem_en, 1);
      chk("wr_aw", mem_aw, 2);
      chk("wr_din", mem_din, 8'h5A);
      chk("wr_cack", c_wack, 0);
      h_wreq = 1'b0;
      cyc();
      chk("wr_ack_pulse", h_wack, 0);
      chk("wr_we_off", mem_we, 0);
      do_read("wr_rd2", 2'd2, 8'h5A);

      // ---- read/write hazard on addr 1
`ifdef STAT_ARB_RDBYP_EN
      hz_exp = 8'h77;
`else
      hz_exp = 8'h00;
`endif
      h_wreq = 1'b1; h_waddr = 2'd1; h_wdata = 8'h77;
      h_rreq = 1'b1; h_raddr = 2'd1;
      cyc();
      h_wreq = 1'b0;
      h_rreq = 1'b0;
      chk("hz_we", mem_we, 1);
      chk("hz_ar", mem_ar, 1);
      cyc();
      chk("hz_rvalid", h_rvalid, 1);
      chk("hz_rdata", h_rdata, hz_exp);
      cyc();
      do_read("hz_rd1", 2'd1, 8'h77);

      // ---- both requesters write addr 3, prio=HOST after reset
      do_reset();
      h_wreq = 1'b1; h_waddr = 2'd3; h_wdata = 8'h11;
      c_wreq = 1'b1; c_waddr = 2'd3; c_wdata = 8'h22;
      cyc();
      chk("same_g1_hack", h_wack, 1);
      chk("same_g1_cack", c_wack, 0);
      chk("same_g1_din", mem_din, 8'h11);
      h_wreq = 1'b0;
      cyc();
      chk("same_g2_hack", h_wack, 0);
      chk("same_g2_cack", c_wack, 1);
      chk("same_g2_we", mem_we, 1);
      chk("same_g2_din", mem_din, 8'h22);
      c_wreq = 1'b0;
      cyc();
      chk("same_idle_we", mem_we, 0);
      do_read("same_rd3", 2'd3, 8'h22);

      // ---- single host requester re-requesting immediately: 1-in-2 duty
      h_wreq = 1'b1; h_waddr = 2'd2; h_wdata = 8'h30;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("single_we_on", mem_we, 1);
         chk("single_ack_on", h_wack, 1);
         chk("single_din", mem_din, 32'h30 + k);
         h_wdata = h_wdata + 8'h01;
         cyc();
         chk("single_we_off", mem_we, 0);
         chk("single_ack_off", h_wack, 0);
      end
      h_wreq = 1'b0;
      cyc();
      chk("single_end_we", mem_we, 0);
      do_read("single_rd2", 2'd2, 8'h32);

      // ---- both continuous: HOST, CORE, HOST, CORE with no idle cycle
      do_reset();
      h_wreq = 1'b1; h_waddr = 2'd0; h_wdata = 8'hA0;
      c_wreq = 1'b1; c_waddr = 2'd1; c_wdata = 8'hC0;
      for (int k = 0; k < 2; k++) begin
         cyc();
         chk("alt_h_we", mem_we, 1);
         chk("alt_h_hack", h_wack, 1);
         chk("alt_h_cack", c_wack, 0);
         chk("alt_h_aw", mem_aw, 0);
         chk("alt_h_din", mem_din, 32'hA0 + k);
         h_wdata = h_wdata + 8'h01;
         cyc();
         chk("alt_c_we", mem_we, 1);
         chk("alt_c_hack", h_wack, 0);
         chk("alt_c_cack", c_wack, 1);
         chk("alt_c_aw", mem_aw, 1);
         chk("alt_c_din", mem_din, 32'hC0 + k);
         c_wdata = c_wdata + 8'h01;
      end
      h_wreq = 1'b0;
      c_wreq = 1'b0;
      cyc();
      chk("alt_end_we", mem_we, 0);
      do_read("alt_rd0", 2'd0, 8'hA1);
      do_read("alt_rd1", 2'd1, 8'hC1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
